cdb_retire_unit: RTL and testbench
==================================

Name: cdb_retire_unit

Overview:
- Consumer end of the common data bus (CDB).
- Snoops every CDB broadcast and returns the broadcast tag to a free-tag FIFO. It then writes the result into the architectural register file and clears the matching register-status entry.
- It hands free tags and source-operand status to the dispatch stage, and tracks one outstanding branch so dispatch can stall.
- Sits between the execution-unit CDB arbiter and the dispatch unit.

Parameters:
- NUM_TAGS, 64, number of rename tags; tag width is clog2(NUM_TAGS) = 6.
- NUM_REGS, 32, architectural registers; x0 is hardwired to zero.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- cdb_valid  in  1  CDB carries a result this cycle.
- cdb_tag  in  6  tag of the broadcast result.
- cdb_data  in  32  result data.
- cdb_branch  in  1  a branch resolved this cycle; may be high with cdb_valid=0.
- cdb_branch_taken  in  1  resolved branch was taken; qualified by cdb_branch.
- cdb_jalr  in  1  resolved op was jalr; treated as a taken branch when cdb_branch=1.
- disp_tag_req  in  1  dispatch requests a tag this cycle.
- disp_rd  in  5  destination register of the dispatched instruction.
- disp_rd_wr  in  1  dispatched instruction writes disp_rd.
- disp_branch  in  1  dispatched instruction is a branch or jalr.
- disp_rs1, disp_rs2  in  5 each  source register indices.
- tag_out  out  6  head of the free-tag FIFO; valid when tag_empty=0.
- tag_empty  out  1  no free tag.
- rs1_data, rs2_data  out  32 each  source value.
- rs1_busy, rs2_busy  out  1 each  source still pending.
- rs1_tag, rs2_tag  out  6 each  producing tag when busy.
- branch_stall  out  1  a dispatched branch is unresolved.
- redirect  out  1  registered one-cycle pulse: the last resolved branch was taken or was jalr.
- overflow_err  out  1  sticky: a tag was returned to a full FIFO.

Behaviour:

Reset (rst=0, asynchronous):
- Free FIFO holds tags 0..63 in order: rd_ptr=0, wr_ptr=0, count=64.
- All busy bits are 0, all register-file entries are 0, branch_stall=0, redirect=0, overflow_err=0.
- Reset mid-operation discards all state, including in-flight allocations.

Tag allocation:
- tag_out = FIFO[rd_ptr], combinational. tag_empty = (count==0).
- A pop occurs when disp_tag_req=1 and tag_empty=0. rd_ptr advances mod 64.
- disp_tag_req=1 while empty: no state change. Dispatch must not rely on tag_out.

Tag return:
- When cdb_valid=1, cdb_tag is pushed at wr_ptr and wr_ptr advances mod 64.
- Pop and push in the same cycle leave count unchanged. This is legal even at count=0 or count=64. At count=0, the returned tag becomes available next cycle, not through a same-cycle bypass.
- Push at count=64 without a pop is dropped and sets overflow_err.

Register status:
- On a pop with disp_rd_wr=1 and disp_rd!=0: busy[disp_rd] <= 1 and rtag[disp_rd] <= tag_out.
- On cdb_valid, every r with busy[r]=1 and rtag[r]==cdb_tag gets rf[r] <= cdb_data and busy[r] <= 0.
- If the same cycle renames r by dispatch, rf[r] is still written, but busy stays 1 and rtag takes the new tag (dispatch wins).
- x0 is never busy and always reads 0.

Source read (combinational, per port):
- If rs==0: data=0, busy=0.
- Else if busy[rs] and cdb_valid and rtag[rs]==cdb_tag: data=cdb_data, busy=0 (CDB bypass).
- Else: data=rf[rs], busy=busy[rs], tag=rtag[rs].
- Reads see pre-dispatch state. Same-cycle rename of rd does not affect rs reads.

Branch tracking:
- A pop with disp_branch=1 sets branch_stall.
- cdb_branch=1 clears branch_stall. redirect <= cdb_branch & (cdb_branch_taken | cdb_jalr); redirect is 0 in all other cycles.
- Simultaneous set and clear: set wins, because the new branch is a later instruction.
- cdb_branch while branch_stall=0 updates redirect only.

Test Plan:
- Reset, then disp_tag_req for 64 consecutive cycles with disp_rd_wr=0 -> tag_out=0,1,...,63 in order. tag_empty=1 after the 64th pop, and a 65th request leaves state unchanged.
- Dispatch rd=4 and receive tag 0, then cdb_valid tag=0 data=0x0000000A. In the broadcast cycle rs1=4 gives data=0xA, busy=0 via bypass. The next cycle it reads 0xA from rf. Tag 0 re-enters the FIFO at its tail.
- Dispatch rd=5 with tag 1, then rd=5 again with tag 2 in the same cycle as cdb_valid tag=1 data=0xB -> busy[5]=1, rtag[5]=2, rf[5]=0xB. A later cdb tag=2 data=0x15 leaves rf[5]=0x15, busy=0.
- Dispatch with disp_branch=1 -> branch_stall=1. cdb_branch=1, cdb_branch_taken=0 -> stall clears and redirect stays 0. Repeat with taken=1 -> redirect=1 for exactly one cycle.
- With the FIFO full (no tags outstanding), cdb_valid tag=7 -> overflow_err=1 and sticky. count stays 64.
- Assert rst low mid-run with 10 tags outstanding -> all busy=0 and tag_out=0. After release, 64 pops succeed.

Source files
------------

// File: rtl/cdb_retire_unit.sv
// cdb_retire_unit: CDB consumer that recycles tags, retires results into the register file and tracks one branch.
module cdb_retire_unit #(
    parameter int NUM_TAGS = 64,
    parameter int NUM_REGS = 32,
    parameter int TW = $clog2(NUM_TAGS),
    parameter int RW = $clog2(NUM_REGS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cdb_valid,
    input  logic [TW-1:0] cdb_tag,
    input  logic [31:0]   cdb_data,
    input  logic          cdb_branch,
    input  logic          cdb_branch_taken,
    input  logic          cdb_jalr,
    input  logic          disp_tag_req,
    input  logic [RW-1:0] disp_rd,
    input  logic          disp_rd_wr,
    input  logic          disp_branch,
    input  logic [RW-1:0] disp_rs1,
    input  logic [RW-1:0] disp_rs2,
    output logic [TW-1:0] tag_out,
    output logic          tag_empty,
    output logic [31:0]   rs1_data,
    output logic [31:0]   rs2_data,
    output logic          rs1_busy,
    output logic          rs2_busy,
    output logic [TW-1:0] rs1_tag,
    output logic [TW-1:0] rs2_tag,
    output logic          branch_stall,
    output logic          redirect,
    output logic          overflow_err
);
    localparam logic [TW:0] FULL_COUNT = (TW+1)'(NUM_TAGS);

    logic [TW-1:0] fifo_q [NUM_TAGS];
    logic [TW-1:0] fifo_d [NUM_TAGS];
    logic [TW-1:0] rtag_q [NUM_REGS];
    logic [TW-1:0] rtag_d [NUM_REGS];
    logic [31:0]   rf_q [NUM_REGS];
    logic [31:0]   rf_d [NUM_REGS];
    logic          busy_q [NUM_REGS];
    logic          busy_d [NUM_REGS];
    logic [TW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [TW:0]   count_q, count_d;
    logic          branch_stall_q, branch_stall_d;
    logic          redirect_q, redirect_d;
    logic          overflow_err_q, overflow_err_d;
    logic          pop, push, full, rs1_hit, rs2_hit;

    assign tag_out   = fifo_q[rd_ptr_q];
    assign tag_empty = count_q == '0;
    assign full      = count_q == FULL_COUNT;
    assign pop       = disp_tag_req && !tag_empty;
    // A return into a full FIFO only fits when a pop frees a slot in the same cycle.
    assign push      = cdb_valid && (!full || pop);

    assign rs1_hit  = busy_q[disp_rs1] && cdb_valid && rtag_q[disp_rs1] == cdb_tag;
    assign rs2_hit  = busy_q[disp_rs2] && cdb_valid && rtag_q[disp_rs2] == cdb_tag;
    assign rs1_data = disp_rs1 == '0 ? '0 : rs1_hit ? cdb_data : rf_q[disp_rs1];
    assign rs2_data = disp_rs2 == '0 ? '0 : rs2_hit ? cdb_data : rf_q[disp_rs2];
    assign rs1_busy = disp_rs1 != '0 && busy_q[disp_rs1] && !rs1_hit;
    assign rs2_busy = disp_rs2 != '0 && busy_q[disp_rs2] && !rs2_hit;
    assign rs1_tag  = rtag_q[disp_rs1];
    assign rs2_tag  = rtag_q[disp_rs2];

    assign branch_stall = branch_stall_q;
    assign redirect     = redirect_q;
    assign overflow_err = overflow_err_q;

    always_comb begin
        fifo_d   = fifo_q;
        busy_d   = busy_q;
        rtag_d   = rtag_q;
        rf_d     = rf_q;
        rd_ptr_d = rd_ptr_q + TW'(pop);
        wr_ptr_d = wr_ptr_q + TW'(push);
        count_d  = count_q + (TW+1)'(push) - (TW+1)'(pop);
        if (push)
            fifo_d[wr_ptr_q] = cdb_tag;
        for (int r = 1; r < NUM_REGS; r++)
            if (cdb_valid && busy_q[r] && rtag_q[r] == cdb_tag) begin
                rf_d[r]   = cdb_data;
                busy_d[r] = 1'b0;
            end
        // Rename is applied after retirement so a same-cycle redispatch keeps the register busy.
        if (pop && disp_rd_wr && disp_rd != '0) begin
            busy_d[disp_rd] = 1'b1;
            rtag_d[disp_rd] = tag_out;
        end
        branch_stall_d = (pop && disp_branch) ? 1'b1 : cdb_branch ? 1'b0 : branch_stall_q;
        redirect_d     = cdb_branch && (cdb_branch_taken || cdb_jalr);
        overflow_err_d = overflow_err_q || (cdb_valid && !push);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_TAGS; i++)
                fifo_q[i] <= TW'(i);
            for (int r = 0; r < NUM_REGS; r++) begin
                busy_q[r] <= 1'b0;
                rtag_q[r] <= '0;
                rf_q[r]   <= '0;
            end
            rd_ptr_q       <= '0;
            wr_ptr_q       <= '0;
            count_q        <= FULL_COUNT;
            branch_stall_q <= 1'b0;
            redirect_q     <= 1'b0;
            overflow_err_q <= 1'b0;
        end else begin
            fifo_q         <= fifo_d;
            busy_q         <= busy_d;
            rtag_q         <= rtag_d;
            rf_q           <= rf_d;
            rd_ptr_q       <= rd_ptr_d;
            wr_ptr_q       <= wr_ptr_d;
            count_q        <= count_d;
            branch_stall_q <= branch_stall_d;
            redirect_q     <= redirect_d;
            overflow_err_q <= overflow_err_d;
        end
    end
endmodule

// File: tb/tb_cdb_retire_unit.sv
// tb_cdb_retire_unit: directed stimulus checked against a queue-based model and hand-computed values.
module tb_cdb_retire_unit;
    logic        clk = 1'b0, rst = 1'b0;
    logic        cdb_valid = 1'b0, cdb_branch = 1'b0, cdb_branch_taken = 1'b0, cdb_jalr = 1'b0;
    logic [5:0]  cdb_tag = '0;
    logic [31:0] cdb_data = '0;
    logic        disp_tag_req = 1'b0, disp_rd_wr = 1'b0, disp_branch = 1'b0;
    logic [4:0]  disp_rd = '0, disp_rs1 = '0, disp_rs2 = '0;
    logic [5:0]  tag_out, rs1_tag, rs2_tag;
    logic        tag_empty, rs1_busy, rs2_busy, branch_stall, redirect, overflow_err;
    logic [31:0] rs1_data, rs2_data;

    int checks = 0, failures = 0;

    int          fq[$];
    logic        m_busy [32];
    logic [5:0]  m_rtag [32];
    logic [31:0] m_rf [32];
    logic        m_stall, m_redir, m_ovf;

    cdb_retire_unit dut (
        .clk(clk), .rst(rst),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .cdb_branch(cdb_branch), .cdb_branch_taken(cdb_branch_taken), .cdb_jalr(cdb_jalr),
        .disp_tag_req(disp_tag_req), .disp_rd(disp_rd), .disp_rd_wr(disp_rd_wr),
        .disp_branch(disp_branch), .disp_rs1(disp_rs1), .disp_rs2(disp_rs2),
        .tag_out(tag_out), .tag_empty(tag_empty),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .rs1_tag(rs1_tag), .rs2_tag(rs2_tag),
        .branch_stall(branch_stall), .redirect(redirect), .overflow_err(overflow_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Free list is a plain queue; register state is a scoreboard of arrays.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            fq.delete();
            for (int i = 0; i < 64; i++) fq.push_back(i);
            for (int r = 0; r < 32; r++) begin
                m_busy[r] = 1'b0;
                m_rtag[r] = '0;
                m_rf[r]   = '0;
            end
            m_stall = 1'b0;
            m_redir = 1'b0;
            m_ovf   = 1'b0;
        end else begin
            automatic bit take = disp_tag_req && fq.size() > 0;
            automatic int t = take ? fq[0] : 0;
            if (take) void'(fq.pop_front());
            if (cdb_valid) begin
                if (fq.size() < 64) fq.push_back(int'(cdb_tag));
                else m_ovf = 1'b1;
            end
            for (int r = 1; r < 32; r++)
                if (cdb_valid && m_busy[r] && m_rtag[r] == cdb_tag) begin
                    m_rf[r]   = cdb_data;
                    m_busy[r] = 1'b0;
                end
            if (take && disp_rd_wr && disp_rd != 0) begin
                m_busy[disp_rd] = 1'b1;
                m_rtag[disp_rd] = 6'(t);
            end
            m_redir = cdb_branch && (cdb_branch_taken || cdb_jalr);
            if (take && disp_branch) m_stall = 1'b1;
            else if (cdb_branch) m_stall = 1'b0;
        end
    end

    function automatic bit exp_fwd(input logic [4:0] rs);
        return rs != 0 && m_busy[rs] && cdb_valid && m_rtag[rs] == cdb_tag;
    endfunction

    function automatic logic [31:0] exp_data(input logic [4:0] rs);
        return rs == 0 ? 32'd0 : exp_fwd(rs) ? cdb_data : m_rf[rs];
    endfunction

    function automatic bit exp_busy(input logic [4:0] rs);
        return rs != 0 && m_busy[rs] && !exp_fwd(rs);
    endfunction

    always @(negedge clk) if (rst) begin
        chk("tag_empty", tag_empty, fq.size() == 0);
        if (fq.size() > 0) chk("tag_out", tag_out, fq[0]);
        chk("rs1_data", rs1_data, exp_data(disp_rs1));
        chk("rs2_data", rs2_data, exp_data(disp_rs2));
        chk("rs1_busy", rs1_busy, exp_busy(disp_rs1));
        chk("rs2_busy", rs2_busy, exp_busy(disp_rs2));
        if (exp_busy(disp_rs1)) chk("rs1_tag", rs1_tag, m_rtag[disp_rs1]);
        if (exp_busy(disp_rs2)) chk("rs2_tag", rs2_tag, m_rtag[disp_rs2]);
        chk("branch_stall", branch_stall, m_stall);
        chk("redirect", redirect, m_redir);
        chk("overflow_err", overflow_err, m_ovf);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cdb_valid = 0; cdb_tag = 0; cdb_data = 0;
        cdb_branch = 0; cdb_branch_taken = 0; cdb_jalr = 0;
        disp_tag_req = 0; disp_rd = 0; disp_rd_wr = 0; disp_branch = 0;
        disp_rs1 = 0; disp_rs2 = 0;
    endtask

    task automatic do_reset();
        idle();
        rst = 0;
        cyc();
        cyc();
        rst = 1;
    endtask

    task automatic drain_all();
        for (int i = 0; i < 64; i++) begin
            idle();
            disp_tag_req = 1; disp_rs2 = 5'(i);
            #1;
            chk("pop_order", tag_out, i);
            chk("pop_avail", tag_empty, 0);
            cyc();
        end
        idle();
        disp_tag_req = 1;
        #1;
        chk("empty_after_64", tag_empty, 1);
    endtask

    initial begin
        do_reset();
        #1;
        chk("reset_tag_out", tag_out, 0);
        chk("reset_stall", branch_stall, 0);
        chk("reset_ovf", overflow_err, 0);
        drain_all();
        cyc();
        #1;
        chk("65th_req_empty", tag_empty, 1);
        cdb_valid = 1; cdb_tag = 5;
        #1;
        chk("no_bypass_empty", tag_empty, 1);
        cyc(); idle();
        #1;
        chk("ret_tag_avail", tag_empty, 0);
        chk("ret_tag_val", tag_out, 5);

        do_reset();
        disp_tag_req = 1; disp_rd = 4; disp_rd_wr = 1; disp_rs1 = 4;
        #1;
        chk("rd4_tag", tag_out, 0);
        chk("rd4_pre_busy", rs1_busy, 0);
        cyc(); idle(); disp_rs1 = 4;
        #1;
        chk("rd4_busy", rs1_busy, 1);
        chk("rd4_rtag", rs1_tag, 0);
        cyc(); idle(); disp_rs1 = 4; cdb_valid = 1; cdb_tag = 0; cdb_data = 32'h0000000A;
        #1;
        chk("rd4_bypass_data", rs1_data, 32'hA);
        chk("rd4_bypass_busy", rs1_busy, 0);
        cyc(); idle(); disp_rs1 = 4;
        #1;
        chk("rd4_rf_data", rs1_data, 32'hA);
        chk("rd4_rf_busy", rs1_busy, 0);

        disp_tag_req = 1; disp_rd = 5; disp_rd_wr = 1;
        #1;
        chk("rd5_tag1", tag_out, 1);
        cyc(); idle(); disp_tag_req = 1; disp_rd = 5; disp_rd_wr = 1;
        cdb_valid = 1; cdb_tag = 1; cdb_data = 32'hB;
        #1;
        chk("rd5_tag2", tag_out, 2);
        cyc(); idle(); disp_rs1 = 5;
        #1;
        chk("rd5_still_busy", rs1_busy, 1);
        chk("rd5_new_tag", rs1_tag, 2);
        chk("rd5_rf_b", rs1_data, 32'hB);
        cyc(); idle(); disp_rs1 = 5; cdb_valid = 1; cdb_tag = 2; cdb_data = 32'h15;
        #1;
        chk("rd5_bypass", rs1_data, 32'h15);
        cyc(); idle(); disp_rs1 = 5;
        #1;
        chk("rd5_rf_15", rs1_data, 32'h15);
        chk("rd5_free", rs1_busy, 0);

        disp_tag_req = 1; disp_rd = 0; disp_rd_wr = 1;
        cyc(); idle();
        #1;
        chk("x0_busy", rs2_busy, 0);
        chk("x0_data", rs2_data, 0);
        chk("fifo_head_4", tag_out, 4);

        disp_tag_req = 1; disp_branch = 1;
        cyc(); idle();
        #1;
        chk("br_stall_set", branch_stall, 1);
        cdb_branch = 1;
        cyc(); idle();
        #1;
        chk("br_nt_clear", branch_stall, 0);
        chk("br_nt_redir", redirect, 0);
        disp_tag_req = 1; disp_branch = 1;
        cyc(); idle(); cdb_branch = 1; cdb_branch_taken = 1;
        #1;
        chk("br2_stall", branch_stall, 1);
        cyc(); idle();
        #1;
        chk("br_t_redir", redirect, 1);
        chk("br_t_clear", branch_stall, 0);
        cyc();
        #1;
        chk("br_redir_pulse", redirect, 0);
        disp_tag_req = 1; disp_branch = 1;
        cyc(); idle(); disp_tag_req = 1; disp_branch = 1; cdb_branch = 1;
        cyc(); idle();
        #1;
        chk("br_set_wins", branch_stall, 1);
        cdb_branch = 1; cdb_jalr = 1;
        cyc(); idle();
        #1;
        chk("jalr_redir", redirect, 1);
        chk("jalr_clear", branch_stall, 0);
        cdb_branch = 1; cdb_branch_taken = 1;
        cyc(); idle();
        #1;
        chk("idle_br_redir", redirect, 1);
        chk("idle_br_stall", branch_stall, 0);
        cyc();
        #1;
        chk("idle_br_pulse", redirect, 0);

        do_reset();
        #1;
        chk("ovf_clear", overflow_err, 0);
        cdb_valid = 1; cdb_tag = 7;
        cyc(); idle();
        #1;
        chk("ovf_set", overflow_err, 1);
        chk("ovf_head", tag_out, 0);
        cyc();
        #1;
        chk("ovf_sticky", overflow_err, 1);
        disp_tag_req = 1; cdb_valid = 1; cdb_tag = 9;
        cyc(); idle();
        #1;
        chk("full_swap_head", tag_out, 1);
        chk("full_swap_avail", tag_empty, 0);

        do_reset();
        for (int i = 0; i < 10; i++) begin
            idle();
            disp_tag_req = 1; disp_rd = 5'(i + 1); disp_rd_wr = 1;
            cyc();
        end
        idle(); disp_rs1 = 3;
        #1;
        chk("pre_rst_busy", rs1_busy, 1);
        chk("pre_rst_tag", rs1_tag, 2);
        rst = 0;
        #1;
        chk("async_rst_busy", rs1_busy, 0);
        chk("async_rst_head", tag_out, 0);
        chk("async_rst_avail", tag_empty, 0);
        cyc();
        rst = 1;
        drain_all();
        cyc(); idle();
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
